u_code_sequencer: RTL

Consumer end of the microcode control interface. It accepts a start pulse and a start address for a complex instruction (MUL/MULS), then walks an internal micro-ROM and injects one micro-op per accepted handshake into the decode stage in place of fetched instructions. It supports a single hardware loop for iterative shift-add sequences. It signals completion so the controller can release the fetch hold.

---
 rtl/u_code_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/u_code_sequencer.sv
// u_code_sequencer: walks the micro-ROM and injects micro-ops into decode, with a single hardware loop
module u_code_sequencer #(
  parameter int ADDR_W = 8,
  parameter int UOP_W = 32,
  parameter int LOOP_CNT = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uc_start,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic              rom_we,
  input  logic [ADDR_W-1:0] rom_waddr,
  input  logic [UOP_W+2:0]  rom_wdata,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [UOP_W-1:0]  uop,
  output logic              uc_busy,
  output logic              uc_done,
  output logic              uc_err
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t st, st_n;
  logic [UOP_W+2:0] mem [2**ADDR_W];
  logic [UOP_W+2:0] rom_q, w, w_n;
  logic [ADDR_W-1:0] upc, upc_n, ret, ret_n, ret_eff;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_eff;
  logic valid_n, busy_n, err_n, acc, arm, last, lend, rep;
  assign uop = w[UOP_W-1:0];
  // Next-state logic. A loop_start word only arms the loop while no loop is active (cnt==0),
  // so jumping back to it does not reload the counter; this also makes a word with both
  // loop_start and loop_end run exactly LOOP_CNT times.
  always_comb begin
    acc = st == ISSUE && uop_ready;
    last = w[UOP_W];
    lend = w[UOP_W+2];
    arm = w[UOP_W+1] && cnt == '0;
    cnt_eff = arm ? CNT_W'(LOOP_CNT) : cnt;
    ret_eff = arm ? upc : ret;
    rep = lend && cnt_eff > CNT_W'(1);
    uc_done = acc && last;
    st_n = st;
    upc_n = upc;
    cnt_n = cnt;
    ret_n = ret;
    w_n = w;
    valid_n = uop_valid;
    busy_n = uc_busy;
    err_n = uc_err | (uc_start && uc_busy && !uc_done);
    unique case (st)
      IDLE: if (uc_start) begin
        st_n = FETCH;
        upc_n = uc_addr;
        busy_n = 1'b1;
      end
      FETCH: begin
        st_n = ISSUE;
        w_n = rom_q;
        valid_n = 1'b1;
      end
      ISSUE: if (acc) begin
        valid_n = 1'b0;
        if (last) begin
          st_n = uc_start ? FETCH : IDLE;
          busy_n = uc_start;
          upc_n = uc_start ? uc_addr : upc;
        end else begin
          st_n = FETCH;
          ret_n = ret_eff;
          cnt_n = rep ? cnt_eff - CNT_W'(1) : (lend ? '0 : cnt_eff);
          upc_n = rep ? ret_eff : upc + ADDR_W'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end
  // Sequencer state and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      upc <= '0;
      cnt <= '0;
      ret <= '0;
      w <= '0;
      uop_valid <= 1'b0;
      uc_busy <= 1'b0;
      uc_err <= 1'b0;
    end else begin
      st <= st_n;
      upc <= upc_n;
      cnt <= cnt_n;
      ret <= ret_n;
      w <= w_n;
      uop_valid <= valid_n;
      uc_busy <= busy_n;
      uc_err <= err_n;
    end
  // Micro-ROM: synchronous read of the next upc, read-before-write on collisions
  always_ff @(posedge clk) begin
    if (rom_we) mem[rom_waddr] <= rom_wdata;
    rom_q <= mem[upc_n];
  end
endmodule
